// File: rtl/muldiv_unit_pkg.sv
// Shared constants, op encodings, FSM states and helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned MD_STEPS = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIX   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Absolute value for signed ops, pass-through otherwise.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

    function automatic logic is_iter(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-divide step: shift in the next dividend bit, trial subtract, pick quotient bit.
module muldiv_unit_div_step
    import muldiv_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // Remainder stays below the divisor, so the top bit is always dropped safely.
    assign o_rem   = XLEN'(w_ge ? w_diff : w_shift);
    assign o_qbit  = w_ge;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit producing the HI/LO write stream, plus MTHI/MTLO pass-through.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic              i_cancel,
    output logic [2*XLEN-1:0] o_hilo_d,
    output logic [1:0]        o_hilo_write,
    output logic              o_busy
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    hilo_t             r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_is_div;
    logic              r_neg_lo;
    logic              r_neg_hi;

    logic              w_launch;
    logic              w_is_signed;
    logic              w_is_div;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_dq_rem;
    logic              w_dq_bit;
    logic [2*XLEN-1:0] w_hilo_d_nxt;
    logic [1:0]        w_hilo_write_nxt;
    logic              w_busy_nxt;

    assign w_launch    = (r_state == ST_IDLE) && i_start && is_iter(i_op);
    assign w_is_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_a_mag     = mag(i_a, w_is_signed);
    assign w_b_mag     = mag(i_b, w_is_signed);
    assign w_sum       = r_acc.lo[0] ? ({1'b0, r_acc.hi} + {1'b0, r_opnd}) : {1'b0, r_acc.hi};

    muldiv_unit_div_step u_div_step (
        .i_rem     (r_acc.hi),
        .i_bit     (r_acc.lo[XLEN-1]),
        .i_divisor (r_opnd),
        .o_rem     (w_dq_rem),
        .o_qbit    (w_dq_bit)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (i_cancel)                               w_state_nxt = ST_IDLE;
                else if (r_cnt == CNT_W'(MD_STEPS - 1))     w_state_nxt = ST_FIX;
            end
            ST_FIX:   w_state_nxt = i_cancel ? ST_IDLE : ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_hilo_d_nxt     = o_hilo_d;
        w_hilo_write_nxt = 2'b00;
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        if (r_state == ST_IDLE && i_start) begin
            if (i_op == OP_MTHI) begin
                w_hilo_d_nxt     = {i_a, {XLEN{1'b0}}};
                w_hilo_write_nxt = 2'b10;
            end else if (i_op == OP_MTLO) begin
                w_hilo_d_nxt     = {{XLEN{1'b0}}, i_a};
                w_hilo_write_nxt = 2'b01;
            end
        end else if (r_state == ST_WRITE) begin
            w_hilo_d_nxt     = r_acc;
            w_hilo_write_nxt = 2'b11;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_hilo_d     <= '0;
            o_hilo_write <= 2'b00;
            o_busy       <= 1'b0;
        end else begin
            o_hilo_d     <= w_hilo_d_nxt;
            o_hilo_write <= w_hilo_write_nxt;
            o_busy       <= w_busy_nxt;
        end
    end

    // Operand latch, shift-add / restoring iteration and sign correction.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        // A zero divisor keeps LO all-ones regardless of operand signs.
                        r_neg_lo <= w_is_signed && (i_a[XLEN-1] ^ i_b[XLEN-1])
                                    && !(w_is_div && (i_b == '0));
                        r_neg_hi <= w_is_signed && w_is_div && i_a[XLEN-1];
                        r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) r_acc <= {w_dq_rem, r_acc.lo[XLEN-2:0], w_dq_bit};
                    else          r_acc <= {w_sum, r_acc.lo[XLEN-1:1]};
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        if (r_neg_hi) r_acc.hi <= XLEN'(-r_acc.hi);
                        if (r_neg_lo) r_acc.lo <= XLEN'(-r_acc.lo);
                    end else if (r_neg_lo) begin
                        r_acc <= hilo_t'(-{r_acc.hi, r_acc.lo});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: iterative ops, MTHI/MTLO, cancel and mid-op reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [63:0] hilo_d;
    logic [1:0]  hilo_write;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_op         (op),
        .i_a          (a),
        .i_b          (b),
        .i_cancel     (cancel),
        .o_hilo_d     (hilo_d),
        .o_hilo_write (hilo_write),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an iterative op and check busy window, strobe timing and result.
    task automatic run_iter(input string tag, input logic [2:0] t_op,
                            input logic [31:0] t_a, input logic [31:0] t_b,
                            input logic [63:0] exp);
        int busy_n = 0;
        int wr_n   = 0;
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        tick();
        start = 1'b0;
        if (busy) busy_n++;
        if (hilo_write != 2'b00) wr_n++;
        for (int k = 1; k < 34; k++) begin
            tick();
            if (busy) busy_n++;
            if (hilo_write != 2'b00) wr_n++;
        end
        chk({tag, " busy cycles"}, 64'(busy_n), 64'd34);
        chk({tag, " early write"}, 64'(wr_n), 64'd0);
        tick();
        chk({tag, " strobe"}, 64'(hilo_write), 64'd3);
        chk({tag, " busy at write"}, 64'(busy), 64'd0);
        chk({tag, " result"}, hilo_d, exp);
        tick();
        chk({tag, " strobe clear"}, 64'(hilo_write), 64'd0);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                          input logic t_cancel, input logic [63:0] exp_d, input logic [1:0] exp_wr);
        start = 1'b1; op = t_op; a = t_a; cancel = t_cancel;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk({tag, " data"}, hilo_d, exp_d);
        chk({tag, " strobe"}, 64'(hilo_write), 64'(exp_wr));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        tick();
        chk({tag, " strobe clear"}, 64'(hilo_write), 64'd0);
    endtask

    initial begin
        int n_bad;
        rst = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        repeat (2) tick();
        chk("reset data", hilo_d, 64'd0);
        chk("reset strobe", 64'(hilo_write), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick();

        run_iter("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_iter("mult -3*5", OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1);
        run_iter("mult -4*-6", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 64'h0000_0000_0000_0018);
        run_iter("div -7/2", OP_DIV,    32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_iter("div 7/-2", OP_DIV,    32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_iter("divu 100/0", OP_DIVU, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF);
        run_iter("div -100/0", OP_DIV,  32'hFFFF_FF9C, 32'd0,         64'hFFFF_FF9C_FFFF_FFFF);
        run_iter("div ovf", OP_DIV,     32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_iter("divu big", OP_DIVU,   32'hFFFF_FFFF, 32'h10,        64'h0000_000F_0FFF_FFFF);

        run_mt("mthi", OP_MTHI, 32'h1234_5678, 1'b0, 64'h1234_5678_0000_0000, 2'b10);
        run_mt("mtlo+cancel", OP_MTLO, 32'hCAFE_F00D, 1'b1, 64'h0000_0000_CAFE_F00D, 2'b01);

        // Undefined op must leave the unit idle.
        start = 1'b1; op = 3'd6; a = 32'h5555_5555;
        tick();
        start = 1'b0;
        chk("undef busy", 64'(busy), 64'd0);
        chk("undef strobe", 64'(hilo_write), 64'd0);

        // DIVU cancelled at cycle 10, with a stray MTHI start while busy.
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        chk("cancel busy start", 64'(busy), 64'd1);
        repeat (4) tick();
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        chk("start while busy strobe", 64'(hilo_write), 64'd0);
        chk("start while busy busy", 64'(busy), 64'd1);
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy drop", 64'(busy), 64'd0);
        chk("cancel no write", 64'(hilo_write), 64'd0);
        run_iter("multu 3*4", OP_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C);

        // Asynchronous reset at cycle 20 of a MULT.
        start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst data", hilo_d, 64'd0);
        chk("async rst strobe", 64'(hilo_write), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        n_bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hilo_write != 2'b00 || busy) n_bad++;
        end
        chk("no stale write", 64'(n_bad), 64'd0);
        run_iter("mult after rst", OP_MULT, 32'd7, 32'd9, 64'h0000_0000_0000_003F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
